// File: rtl/msg_link_pkg.sv
// Shared definitions for the GPIO message link arbiter.
//   - state_t      : transfer sequencer states
//   - SRC_KB/PRE   : requester identifiers used for grants and last_src
//   - DEF_MSG_W    : default message width (16 ASCII characters)
//   - ASCII_SPACES : a 16-character blank message
package msg_link_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam logic SRC_KB  = 1'b0;
    localparam logic SRC_PRE = 1'b1;

    localparam int DEF_MSG_W = 128;

    localparam logic [127:0] ASCII_SPACES = {16{8'h20}};

endpackage

// File: rtl/msg_tx_arbiter_rr_arb2.sv
// Two-way round-robin pick between the keyboard and preset requesters.
// Ports:
//   kb_req, pre_req : request levels
//   last_src        : source of the previous grant
//   win_valid       : at least one request is present
//   win_src         : winning source (SRC_KB / SRC_PRE)
module rr_arb2
    import msg_link_pkg::*;
(
    input  logic kb_req,
    input  logic pre_req,
    input  logic last_src,
    output logic win_valid,
    output logic win_src
);

    always_comb begin
        win_valid = kb_req | pre_req;
        if (kb_req && pre_req) begin
            // On a tie, the side that did not win last time goes first.
            win_src = ~last_src;
        end else if (pre_req) begin
            win_src = SRC_PRE;
        end else begin
            win_src = SRC_KB;
        end
    end

endmodule

// File: rtl/msg_tx_arbiter.sv
// Shares the GPIO message link between the keyboard composer and the preset
// selector. Latches the granted message and sequences data_ready/done with a
// timeout, a low gap between attempts and a bounded number of retries.
// Ports:
//   clock, reset              : system clock, asynchronous active-high reset
//   kb_req/kb_msg/kb_grant    : keyboard requester (grant = 1-cycle pulse)
//   pre_req/pre_msg/pre_grant : preset requester (grant = 1-cycle pulse)
//   link_done                 : done level from gpio_protocol
//   link_data_ready           : data_ready to gpio_protocol
//   link_message_out          : latched payload to gpio_protocol
//   busy                      : sequencer is not idle
//   last_src                  : source of the most recent grant (0 kb, 1 pre)
//   tx_ok / tx_fail           : 1-cycle pulses on completed / abandoned transfer
module msg_tx_arbiter
    import msg_link_pkg::*;
#(
    parameter int MSG_W          = DEF_MSG_W,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int GAP_CYCLES     = 4,
    parameter int MAX_RETRY      = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             kb_req,
    input  logic [MSG_W-1:0] kb_msg,
    output logic             kb_grant,
    input  logic             pre_req,
    input  logic [MSG_W-1:0] pre_msg,
    output logic             pre_grant,
    input  logic             link_done,
    output logic             link_data_ready,
    output logic [MSG_W-1:0] link_message_out,
    output logic             busy,
    output logic             last_src,
    output logic             tx_ok,
    output logic             tx_fail
);

    localparam int TMAX    = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    state_t             state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic [RETRY_W-1:0] retry_cnt, retry_nxt;
    logic               done_q;
    logic               drdy_nxt, kb_grant_nxt, pre_grant_nxt;
    logic               tx_ok_nxt, tx_fail_nxt, last_src_nxt;
    logic [MSG_W-1:0]   msg_nxt;
    logic               win_valid, win_src;
    logic               success;

    rr_arb2 u_arb (
        .kb_req    (kb_req),
        .pre_req   (pre_req),
        .last_src  (last_src),
        .win_valid (win_valid),
        .win_src   (win_src)
    );

    // Only a fresh rising edge of done counts, so a done left high from a
    // previous transfer cannot complete a new one.
    assign success = link_done & ~done_q;
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        retry_nxt     = retry_cnt;
        drdy_nxt      = link_data_ready;
        msg_nxt       = link_message_out;
        last_src_nxt  = last_src;
        kb_grant_nxt  = 1'b0;
        pre_grant_nxt = 1'b0;
        tx_ok_nxt     = 1'b0;
        tx_fail_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (win_valid) begin
                    msg_nxt       = (win_src == SRC_PRE) ? pre_msg : kb_msg;
                    kb_grant_nxt  = (win_src == SRC_KB);
                    pre_grant_nxt = (win_src == SRC_PRE);
                    last_src_nxt  = win_src;
                    drdy_nxt      = 1'b1;
                    timer_nxt     = '0;
                    retry_nxt     = '0;
                    state_nxt     = SEND;
                end
            end
            SEND: begin
                if (success) begin
                    drdy_nxt  = 1'b0;
                    tx_ok_nxt = 1'b1;
                    timer_nxt = '0;
                    state_nxt = RELEASE;
                end else if (timer == TIMEOUT_LAST) begin
                    drdy_nxt  = 1'b0;
                    timer_nxt = '0;
                    if (retry_cnt == RETRY_LIMIT) begin
                        tx_fail_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        retry_nxt = retry_cnt + RETRY_W'(1);
                        state_nxt = GAP;
                    end
                end else begin
                    timer_nxt = timer + TIMER_W'(1);
                end
            end
            RELEASE: begin
                if (!link_done) begin
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                // Timer parks at its last value while done is still high.
                if (timer == GAP_LAST) begin
                    if (!link_done) begin
                        drdy_nxt  = 1'b1;
                        timer_nxt = '0;
                        state_nxt = SEND;
                    end
                end else begin
                    timer_nxt = timer + TIMER_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            timer            <= '0;
            retry_cnt        <= '0;
            done_q           <= 1'b0;
            link_data_ready  <= 1'b0;
            link_message_out <= '0;
            last_src         <= SRC_PRE;
            kb_grant         <= 1'b0;
            pre_grant        <= 1'b0;
            tx_ok            <= 1'b0;
            tx_fail          <= 1'b0;
        end else begin
            state            <= state_nxt;
            timer            <= timer_nxt;
            retry_cnt        <= retry_nxt;
            done_q           <= link_done;
            link_data_ready  <= drdy_nxt;
            link_message_out <= msg_nxt;
            last_src         <= last_src_nxt;
            kb_grant         <= kb_grant_nxt;
            pre_grant        <= pre_grant_nxt;
            tx_ok            <= tx_ok_nxt;
            tx_fail          <= tx_fail_nxt;
        end
    end

endmodule

// File: tb/tb_msg_tx_arbiter.sv
// Self-checking bench for msg_tx_arbiter with a short timeout so retries and
// abandonment can be exercised quickly.
module tb_msg_tx_arbiter;
    import msg_link_pkg::*;

    localparam int W       = 128;
    localparam int TO      = 16;
    localparam int GAPC    = 4;
    localparam int MRETRY  = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         kb_req, pre_req, link_done;
    logic [W-1:0] kb_msg, pre_msg;
    logic         kb_grant, pre_grant, link_data_ready, busy, last_src, tx_ok, tx_fail;
    logic [W-1:0] link_message_out;

    int checks = 0;
    int failures = 0;
    int ok_seen = 0;
    int fail_seen = 0;
    logic model_last;

    msg_tx_arbiter #(
        .MSG_W(W), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAPC), .MAX_RETRY(MRETRY)
    ) dut (
        .clock(clock), .reset(reset),
        .kb_req(kb_req), .kb_msg(kb_msg), .kb_grant(kb_grant),
        .pre_req(pre_req), .pre_msg(pre_msg), .pre_grant(pre_grant),
        .link_done(link_done), .link_data_ready(link_data_ready),
        .link_message_out(link_message_out), .busy(busy), .last_src(last_src),
        .tx_ok(tx_ok), .tx_fail(tx_fail)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (tx_ok === 1'b1) ok_seen++;
        if (tx_fail === 1'b1) fail_seen++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [W-1:0] rand_msg();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_last = SRC_PRE;
    endtask

    task automatic test_reset();
        reset = 1'b1; kb_req = 0; pre_req = 0; link_done = 0; kb_msg = '0; pre_msg = '0;
        tick(); tick();
        checks++; if (link_data_ready !== 1'b0) begin failures++; $display("FAIL rst_drdy: got %b want 0", link_data_ready); end
        checks++; if (link_message_out !== '0) begin failures++; $display("FAIL rst_msg: got %h want 0", link_message_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (last_src !== 1'b1) begin failures++; $display("FAIL rst_last_src: got %b want 1", last_src); end
        checks++; if ({kb_grant, pre_grant, tx_ok, tx_fail} !== 4'b0) begin failures++; $display("FAIL rst_pulses: got %b want 0000", {kb_grant, pre_grant, tx_ok, tx_fail}); end
        reset = 1'b0;
        model_last = SRC_PRE;
    endtask

    task automatic test_single();
        logic [W-1:0] m;
        m = ASCII_SPACES;
        m[15:0] = 16'h293A;
        kb_msg = m; kb_req = 1'b1;
        tick();
        checks++; if (kb_grant !== 1'b1 || pre_grant !== 1'b0) begin failures++; $display("FAIL t1_grant: got kb=%b pre=%b want kb=1 pre=0", kb_grant, pre_grant); end
        checks++; if (link_data_ready !== 1'b1) begin failures++; $display("FAIL t1_drdy: got %b want 1", link_data_ready); end
        checks++; if (link_message_out !== m) begin failures++; $display("FAIL t1_msg: got %h want %h", link_message_out, m); end
        kb_req = 1'b0; kb_msg = rand_msg();
        model_last = SRC_KB;
        tick();
        checks++; if (kb_grant !== 1'b0) begin failures++; $display("FAIL t1_grant_pulse: got %b want 0", kb_grant); end
        repeat (4) tick();
        link_done = 1'b1;
        tick();
        checks++; if (tx_ok !== 1'b1 || link_data_ready !== 1'b0) begin failures++; $display("FAIL t1_ok: got ok=%b drdy=%b want ok=1 drdy=0", tx_ok, link_data_ready); end
        tick(); tick();
        checks++; if (busy !== 1'b1 || tx_ok !== 1'b0) begin failures++; $display("FAIL t1_release: got busy=%b ok=%b want busy=1 ok=0", busy, tx_ok); end
        link_done = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t1_idle: got busy=%b want 0", busy); end
        checks++; if (link_message_out !== m) begin failures++; $display("FAIL t1_msg_hold: got %h want %h", link_message_out, m); end
    endtask

    task automatic test_tie();
        logic         exp_src;
        logic [W-1:0] exp_msg;
        apply_reset();
        kb_msg = rand_msg(); pre_msg = rand_msg();
        kb_req = 1'b1; pre_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_src = ~model_last;
            exp_msg = exp_src ? pre_msg : kb_msg;
            tick();
            checks++; if (kb_grant !== ~exp_src || pre_grant !== exp_src) begin failures++; $display("FAIL t2_grant%0d: got kb=%b pre=%b want src=%b", i, kb_grant, pre_grant, exp_src); end
            checks++; if (last_src !== exp_src) begin failures++; $display("FAIL t2_last_src%0d: got %b want %b", i, last_src, exp_src); end
            checks++; if (link_message_out !== exp_msg) begin failures++; $display("FAIL t2_msg%0d: got %h want %h", i, link_message_out, exp_msg); end
            model_last = exp_src;
            kb_msg = rand_msg(); pre_msg = rand_msg();
            tick(); tick();
            link_done = 1'b1;
            tick();
            checks++; if (tx_ok !== 1'b1 || link_message_out !== exp_msg) begin failures++; $display("FAIL t2_ok%0d: got ok=%b msg=%h want ok=1 msg=%h", i, tx_ok, link_message_out, exp_msg); end
            link_done = 1'b0;
            tick();
        end
        kb_req = 1'b0; pre_req = 1'b0;
        tick();
    endtask

    task automatic test_retry_success();
        int n;
        int f0;
        logic [W-1:0] m;
        f0 = fail_seen;
        m = rand_msg(); pre_msg = m; pre_req = 1'b1;
        tick();
        checks++; if (pre_grant !== 1'b1 || link_message_out !== m) begin failures++; $display("FAIL t3_grant: got pre=%b msg=%h want 1 %h", pre_grant, link_message_out, m); end
        pre_req = 1'b0; pre_msg = rand_msg();
        model_last = SRC_PRE;
        n = 0;
        while (link_data_ready === 1'b1 && n < 64) begin n++; tick(); end
        checks++; if (n != TO) begin failures++; $display("FAIL t3_send_len: got %0d want %0d", n, TO); end
        n = 0;
        while (link_data_ready === 1'b0 && busy === 1'b1 && n < 64) begin n++; tick(); end
        checks++; if (n != GAPC) begin failures++; $display("FAIL t3_gap_len: got %0d want %0d", n, GAPC); end
        checks++; if (link_data_ready !== 1'b1 || link_message_out !== m) begin failures++; $display("FAIL t3_resend: got drdy=%b msg=%h want 1 %h", link_data_ready, link_message_out, m); end
        tick(); tick();
        link_done = 1'b1;
        tick();
        checks++; if (tx_ok !== 1'b1) begin failures++; $display("FAIL t3_ok: got %b want 1", tx_ok); end
        link_done = 1'b0;
        tick();
        checks++; if (fail_seen != f0 || busy !== 1'b0) begin failures++; $display("FAIL t3_no_fail: got fails=%0d busy=%b want %0d 0", fail_seen - f0, busy, 0); end
    endtask

    task automatic test_abandon();
        int n;
        int f0;
        logic [W-1:0] m;
        f0 = fail_seen;
        m = rand_msg(); kb_msg = m; kb_req = 1'b1;
        tick();
        kb_req = 1'b0; kb_msg = rand_msg();
        model_last = SRC_KB;
        for (int w = 0; w <= MRETRY; w++) begin
            n = 0;
            while (link_data_ready === 1'b1 && n < 64) begin n++; tick(); end
            checks++; if (n != TO) begin failures++; $display("FAIL t4_send_len%0d: got %0d want %0d", w, n, TO); end
            checks++; if (link_message_out !== m) begin failures++; $display("FAIL t4_msg%0d: got %h want %h", w, link_message_out, m); end
            if (w < MRETRY) begin
                n = 0;
                while (link_data_ready === 1'b0 && busy === 1'b1 && n < 64) begin n++; tick(); end
                checks++; if (n != GAPC) begin failures++; $display("FAIL t4_gap_len%0d: got %0d want %0d", w, n, GAPC); end
            end
        end
        checks++; if (tx_fail !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL t4_abandon: got fail=%b busy=%b want 1 0", tx_fail, busy); end
        tick();
        checks++; if (fail_seen - f0 != 1 || tx_fail !== 1'b0) begin failures++; $display("FAIL t4_fail_once: got %0d pulses want 1", fail_seen - f0); end
    endtask

    task automatic test_reset_mid_send();
        int o0, f0;
        logic [W-1:0] m;
        m = rand_msg(); kb_msg = m; kb_req = 1'b1;
        tick();
        checks++; if (kb_grant !== 1'b1) begin failures++; $display("FAIL t5_grant: got %b want 1", kb_grant); end
        repeat (3) tick();
        o0 = ok_seen; f0 = fail_seen;
        reset = 1'b1;
        #1;
        checks++; if (link_data_ready !== 1'b0 || busy !== 1'b0 || link_message_out !== '0 || last_src !== 1'b1) begin failures++; $display("FAIL t5_async: got drdy=%b busy=%b last=%b msg=%h want 0 0 1 0", link_data_ready, busy, last_src, link_message_out); end
        tick(); tick();
        reset = 1'b0;
        model_last = SRC_PRE;
        checks++; if (ok_seen != o0 || fail_seen != f0) begin failures++; $display("FAIL t5_no_pulse: got ok=%0d fail=%0d want 0 0", ok_seen - o0, fail_seen - f0); end
        tick();
        checks++; if (kb_grant !== 1'b1 || link_message_out !== m) begin failures++; $display("FAIL t5_regrant: got kb=%b msg=%h want 1 %h", kb_grant, link_message_out, m); end
        kb_req = 1'b0;
        model_last = SRC_KB;
        link_done = 1'b1; tick();
        link_done = 1'b0; tick();
    endtask

    task automatic test_done_stuck();
        int o0;
        logic [W-1:0] m;
        link_done = 1'b1;
        tick(); tick();
        m = rand_msg(); pre_msg = m; pre_req = 1'b1;
        tick();
        checks++; if (pre_grant !== 1'b1 || link_data_ready !== 1'b1) begin failures++; $display("FAIL t6_grant: got pre=%b drdy=%b want 1 1", pre_grant, link_data_ready); end
        pre_req = 1'b0;
        model_last = SRC_PRE;
        o0 = ok_seen;
        repeat (3) tick();
        checks++; if (ok_seen != o0 || link_data_ready !== 1'b1) begin failures++; $display("FAIL t6_no_early_ok: got ok=%0d drdy=%b want 0 1", ok_seen - o0, link_data_ready); end
        link_done = 1'b0; tick();
        link_done = 1'b1; tick();
        checks++; if (tx_ok !== 1'b1) begin failures++; $display("FAIL t6_ok: got %b want 1", tx_ok); end
        kb_msg = rand_msg(); kb_req = 1'b1;
        repeat (5) begin
            tick();
            checks++; if (kb_grant !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL t6_hold: got kb=%b busy=%b want 0 1", kb_grant, busy); end
        end
        link_done = 1'b0; tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t6_idle: got %b want 0", busy); end
        tick();
        checks++; if (kb_grant !== 1'b1 || link_message_out !== kb_msg) begin failures++; $display("FAIL t6_next: got kb=%b msg=%h want 1 %h", kb_grant, link_message_out, kb_msg); end
        kb_req = 1'b0;
        model_last = SRC_KB;
        link_done = 1'b1; tick();
        link_done = 1'b0; tick();
    endtask

    task automatic test_random();
        logic         k, p, exp_src;
        logic [W-1:0] exp_msg;
        int           lat;
        for (int r = 0; r < 24; r++) begin
            k = 1'($urandom_range(0, 1));
            p = 1'($urandom_range(0, 1));
            if (!k && !p) k = 1'b1;
            kb_msg = rand_msg(); pre_msg = rand_msg();
            kb_req = k; pre_req = p;
            exp_src = (k && p) ? ~model_last : p;
            exp_msg = exp_src ? pre_msg : kb_msg;
            tick();
            checks++; if (kb_grant !== ~exp_src || pre_grant !== exp_src || last_src !== exp_src) begin failures++; $display("FAIL rnd_grant%0d: got kb=%b pre=%b last=%b want src=%b", r, kb_grant, pre_grant, last_src, exp_src); end
            model_last = exp_src;
            kb_req = 1'b0; pre_req = 1'b0;
            kb_msg = rand_msg(); pre_msg = rand_msg();
            lat = $urandom_range(1, 10);
            repeat (lat) tick();
            checks++; if (link_data_ready !== 1'b1 || link_message_out !== exp_msg) begin failures++; $display("FAIL rnd_hold%0d: got drdy=%b msg=%h want 1 %h", r, link_data_ready, link_message_out, exp_msg); end
            link_done = 1'b1; tick();
            checks++; if (tx_ok !== 1'b1) begin failures++; $display("FAIL rnd_ok%0d: got %b want 1", r, tx_ok); end
            link_done = 1'b0; tick();
        end
    endtask

    initial begin
        model_last = SRC_PRE;
        test_reset();
        test_single();
        test_tie();
        test_retry_success();
        test_abandon();
        test_reset_mid_send();
        test_done_stuck();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msg_tx_arbiter.md
Name: msg_tx_arbiter

Overview:
- Shares the single GPIO message link (gpio_protocol: data_ready out, done in, 128-bit message_out) between two requesters: the keyboard/LCD composer and the preset emoji/message selector.
- Arbitrates round-robin and latches the granted 128-bit message, so the link payload is stable for the whole transfer.
- Sequences the data_ready/done handshake, with a timeout and bounded retry.
- Replaces the combinational preset/keyboard mux and the edge-triggered data_ready latch in the top level.

Parameters:
- MSG_W, 128, message width in bits (16 ASCII chars).
- TIMEOUT_CYCLES, 50000000, clock cycles in SEND before a retry (1 s at CLOCK_50).
- GAP_CYCLES, 4, cycles data_ready is held low between retries.
- MAX_RETRY, 3, retries after the first attempt before the transfer is abandoned.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- kb_req  in  1  keyboard requester has a message (level).
- kb_msg  in  MSG_W  keyboard message.
- kb_grant  out  1  one-cycle pulse: kb_msg latched.
- pre_req  in  1  preset requester has a message (level).
- pre_msg  in  MSG_W  preset message.
- pre_grant  out  1  one-cycle pulse: pre_msg latched.
- link_done  in  1  gpio_protocol done (same clock domain, level).
- link_data_ready  out  1  to gpio_protocol data_ready.
- link_message_out  out  MSG_W  latched payload to gpio_protocol.
- busy  out  1  high in any state other than IDLE.
- last_src  out  1  source of the most recent grant (0 = kb, 1 = pre).
- tx_ok  out  1  one-cycle pulse on completed transfer.
- tx_fail  out  1  one-cycle pulse on abandoned transfer.

Behaviour:
- Reset values (asynchronous, all outputs and state):
  - state = IDLE; link_data_ready = 0; link_message_out = 0.
  - grants, tx_ok, tx_fail = 0; busy = 0.
  - last_src = 1, so kb wins the first tie.
  - retry_cnt = 0; timer = 0; done_q = 0.
- States: IDLE, SEND, RELEASE, GAP.
- IDLE:
  - On a clock edge with any req high, pick a winner.
  - Only one request high: that requester wins.
  - Both high: the requester not equal to last_src wins.
  - Same edge: latch the winner's msg into link_message_out, pulse its grant, set last_src, set link_data_ready = 1, clear timer and retry_cnt, go to SEND.
  - Grant and data_ready are visible in the cycle after the req is sampled (1-cycle latency).
  - A req dropped before it is sampled is treated as withdrawn; no grant is issued.
- SEND:
  - done_q registers link_done; success = link_done & ~done_q (rising edge).
  - On success: link_data_ready = 0, pulse tx_ok, go to RELEASE.
  - Otherwise timer increments. When timer == TIMEOUT_CYCLES-1 with no success:
    - If retry_cnt == MAX_RETRY: link_data_ready = 0, pulse tx_fail, go to IDLE.
    - Else: link_data_ready = 0, retry_cnt++, timer = 0, go to GAP.
  - Success wins over timeout when both occur on the same edge.
- GAP:
  - link_data_ready stays 0 and link_done is ignored; timer counts.
  - At timer == GAP_CYCLES-1 and link_done == 0: link_data_ready = 1, timer = 0, go to SEND.
  - If link_done is still high at that point, remain in GAP until it falls.
- RELEASE:
  - Wait for link_done == 0, then go to IDLE.
  - The earliest next grant is the edge after IDLE is entered.
  - No request is accepted while link_done is high.
- link_message_out holds the latched value until the next grant. It does not change during retries.
- link_done high while in IDLE is ignored; it does not block the start of a SEND.
- Requests arriving while busy stay pending (level) and are arbitrated on return to IDLE.
- Reset asserted mid-transfer: link_data_ready drops immediately (asynchronous), no tx_fail pulse is issued, and the pending payload is discarded.
- Counters: timer width = clog2(max(TIMEOUT_CYCLES, GAP_CYCLES)); retry_cnt width = clog2(MAX_RETRY+1). Neither counter wraps; each is cleared on every state entry that uses it.

Decomposition:
- Shared package (msg_link_pkg):
  - state encoding: IDLE = 2'd0, SEND = 2'd1, RELEASE = 2'd2, GAP = 2'd3.
  - source constants: SRC_KB = 1'b0, SRC_PRE = 1'b1.
  - MSG_W default.
  - ASCII space fill constant 128'h2020…20.
- One sub-module: rr_arb2 (combinational two-way round-robin pick from kb_req, pre_req, last_src). The FSM, timer and payload register stay in msg_tx_arbiter.

Test Plan (bench parameters: TIMEOUT_CYCLES = 16, GAP_CYCLES = 4, MAX_RETRY = 2):
1. Single request: kb_req = 1, kb_msg = 128'h…2029_3A (":)" padded).
   - kb_grant pulses one cycle after the req is sampled; link_data_ready = 1; link_message_out = kb_msg.
   - link_done rises 5 cycles later: tx_ok pulses, data_ready = 0. Hold done 3 cycles: IDLE is reached after done falls.
2. Tie from reset: kb_req and pre_req both held high.
   - Grants in order kb, pre, kb, pre across four completed transfers; last_src toggles 0, 1, 0, 1.
3. Timeout and retry, then success: pre_req, never assert done.
   - data_ready is high for 16 cycles, low for 4, high again; retry_cnt = 1.
   - Assert done during the 2nd SEND: tx_ok, no tx_fail.
4. Abandon: no done ever.
   - Exactly 3 SEND windows of 16 cycles separated by 2 GAPs of 4; then tx_fail pulses once and busy = 0.
   - link_message_out is unchanged throughout.
5. Reset mid-SEND: assert reset 3 cycles into SEND.
   - All outputs at reset values in the same cycle; no tx_ok or tx_fail pulse.
   - After release, a still-high kb_req is regranted.
6. done stuck high: link_done = 1 before the request and stays high.
   - Request is granted; no success is detected until link_done falls and rises again.
   - After success, RELEASE holds and no new grant is issued while done stays high.
